// File: rtl/topk_pkg.sv
// Shared types and constants for the streaming K-th-maximum tracker.
// TOPK_SIGNED_EN selects two's-complement samples (empty slot = most negative value).
package topk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

  // Value held by an empty slot; callers truncate to their DATA_W (<= 64).
  function automatic logic [63:0] empty_slot(input int data_w);
`ifdef TOPK_SIGNED_EN
    return 64'd1 << (data_w - 1);
`else
    return 64'd0;
`endif
  endfunction

endpackage

// File: rtl/topk_slot.sv
// One rank of the sorted insertion array: either shifts in the value from
// the rank above, captures the new sample, or keeps its own value.
module topk_slot
  import topk_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] cur,
  input  logic [DATA_W-1:0] above_val,
  input  logic              above_flag,
  output logic [DATA_W-1:0] next_val,
  output logic              flag
);

  logic gt;

  // Strictly greater, so an equal sample lands after the existing entry.
`ifdef TOPK_SIGNED_EN
  assign gt = $signed(sample) > $signed(cur);
`else
  assign gt = sample > cur;
`endif

  assign flag = above_flag | gt;

  always_comb begin
    next_val = cur;
    if (above_flag) begin
      next_val = above_val;
    end else if (gt) begin
      next_val = sample;
    end
  end

endmodule

// File: rtl/topk_tracker.sv
// Streaming K-th-maximum finder: collects `count` samples per frame, keeps a
// descending top-K list and reports max / K-th largest with a done pulse.
// Handshake: a sample is consumed in any cycle where valid=1 and the block is
// collecting (COLLECT, or any state when start=1 with count!=0); no backpressure.
// Build option: TOPK_SIGNED_EN (signed samples).
module topk_tracker
  import topk_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K      = 2,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_out,
  output logic [DATA_W-1:0] kth_max
);

  localparam logic [DATA_W-1:0] EMPTY = DATA_W'(empty_slot(DATA_W));
  localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] top_q [K];
  logic [DATA_W-1:0] top_d [K];
  logic [DATA_W-1:0] base  [K];
  logic [DATA_W-1:0] above [K];
  logic [DATA_W-1:0] ins   [K];
  logic [K:0]        flag;
  logic              do_insert;

  // A start cycle inserts into a freshly cleared list, not the old frame.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      base[i] = start ? EMPTY : top_q[i];
    end
    above[0] = EMPTY;
    for (int i = 1; i < K; i++) begin
      above[i] = base[i-1];
    end
  end

  assign flag[0] = 1'b0;

  for (genvar g = 0; g < K; g++) begin : g_slot
    topk_slot #(.DATA_W(DATA_W)) u_slot (
      .sample     (data_in),
      .cur        (base[g]),
      .above_val  (above[g]),
      .above_flag (flag[g]),
      .next_val   (ins[g]),
      .flag       (flag[g+1])
    );
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    do_insert = 1'b0;
    if (start) begin
      if (count == '0) begin
        rem_d   = '0;
        state_d = REPORT;
      end else if (valid) begin
        do_insert = 1'b1;
        rem_d     = count - ONE;
        state_d   = (rem_d == '0) ? REPORT : COLLECT;
      end else begin
        rem_d   = count;
        state_d = COLLECT;
      end
    end else begin
      case (state_q)
        COLLECT: begin
          if (valid) begin
            do_insert = 1'b1;
            rem_d     = (rem_q != '0) ? rem_q - ONE : '0;
            if (rem_d == '0) begin
              state_d = REPORT;
            end
          end
        end
        REPORT:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    for (int i = 0; i < K; i++) begin
      top_d[i] = do_insert ? ins[i] : base[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      max_out <= EMPTY;
      kth_max <= EMPTY;
      for (int i = 0; i < K; i++) begin
        top_q[i] <= EMPTY;
      end
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      for (int i = 0; i < K; i++) begin
        top_q[i] <= top_d[i];
      end
      // Results are captured on entry to REPORT so they are visible with done.
      if (state_d == REPORT) begin
        max_out <= top_d[0];
        kth_max <= top_d[K-1];
      end
    end
  end

  assign busy = (state_q == COLLECT);
  assign done = (state_q == REPORT);

endmodule

// File: tb/tb_topk_tracker.sv
// Directed bench for topk_tracker (K=2, DATA_W=8, CNT_W=3).
module tb_topk_tracker;

`ifdef TOPK_SIGNED_EN
  localparam logic [7:0] EMP = 8'h80;
`else
  localparam logic [7:0] EMP = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] count = '0;
  logic       valid = 1'b0;
  logic [7:0] data_in = '0;
  logic       busy, done;
  logic [7:0] max_out, kth_max;

  int n_assert = 0;
  int n_fail   = 0;

  topk_tracker #(.DATA_W(8), .K(2), .CNT_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .count   (count),
    .valid   (valid),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .max_out (max_out),
    .kth_max (kth_max)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one clock, then settle just after the rising edge.
  task automatic step(input logic s, input logic [2:0] c, input logic v, input logic [7:0] d);
    start = s; count = c; valid = v; data_in = d;
    @(posedge clk);
    #1;
    start = 1'b0; valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic b, input logic dn,
                           input logic [7:0] mx, input logic [7:0] kx);
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(dn));
    check({tag, "_max"},  32'(max_out), 32'(mx));
    check({tag, "_kth"},  32'(kth_max), 32'(kx));
  endtask

  initial begin
    #2;
    check_out("reset", 1'b0, 1'b0, EMP, EMP);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame 1: 5,9,3,7
    step(1'b1, 3'd4, 1'b0, 8'd0);
    check_out("f1_start", 1'b1, 1'b0, EMP, EMP);
    step(1'b0, 3'd0, 1'b1, 8'd5);
    step(1'b0, 3'd0, 1'b1, 8'd9);
    step(1'b0, 3'd0, 1'b1, 8'd3);
    check_out("f1_mid", 1'b1, 1'b0, EMP, EMP);
    step(1'b0, 3'd0, 1'b1, 8'd7);
    check_out("f1_done", 1'b0, 1'b1, 8'd9, 8'd7);
    step(1'b0, 3'd0, 1'b0, 8'd0);
    check_out("f1_hold", 1'b0, 1'b0, 8'd9, 8'd7);

    // Frame 2: duplicates 9,9,1
    step(1'b1, 3'd3, 1'b0, 8'd0);
    step(1'b0, 3'd0, 1'b1, 8'd9);
    step(1'b0, 3'd0, 1'b1, 8'd9);
    step(1'b0, 3'd0, 1'b1, 8'd1);
    check_out("f2_done", 1'b0, 1'b1, 8'd9, 8'd9);

    // Frame 3 starts during REPORT with its only sample: count=1, sample 4
    step(1'b1, 3'd1, 1'b1, 8'd4);
    check_out("f3_done", 1'b0, 1'b1, 8'd4, EMP);
    step(1'b0, 3'd0, 1'b0, 8'd0);
    check_out("f3_idle", 1'b0, 1'b0, 8'd4, EMP);

    // Frame 4 aborted by a restart carrying its first sample
    step(1'b1, 3'd3, 1'b0, 8'd0);
    step(1'b0, 3'd0, 1'b1, 8'd200);
    step(1'b1, 3'd2, 1'b1, 8'd10);
    check_out("f4_restart", 1'b1, 1'b0, 8'd4, EMP);
    step(1'b0, 3'd0, 1'b1, 8'd20);
    check_out("f4_done", 1'b0, 1'b1, 8'd20, 8'd10);
    step(1'b0, 3'd0, 1'b0, 8'd0);

    // Reset mid-frame after 30,40
    step(1'b1, 3'd4, 1'b0, 8'd0);
    step(1'b0, 3'd0, 1'b1, 8'd30);
    step(1'b0, 3'd0, 1'b1, 8'd40);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("rst_mid", 1'b0, 1'b0, EMP, EMP);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_out("rst_hold", 1'b0, 1'b0, EMP, EMP);
    step(1'b1, 3'd2, 1'b0, 8'd0);
    step(1'b0, 3'd0, 1'b1, 8'd1);
    step(1'b0, 3'd0, 1'b1, 8'd2);
    check_out("f5_done", 1'b0, 1'b1, 8'd2, 8'd1);
    step(1'b0, 3'd0, 1'b0, 8'd0);

    // count=0 frame, then stray valid while idle
    step(1'b1, 3'd0, 1'b0, 8'd0);
    check_out("f6_done", 1'b0, 1'b1, EMP, EMP);
    step(1'b0, 3'd0, 1'b1, 8'd50);
    check_out("f6_idle_valid", 1'b0, 1'b0, EMP, EMP);
    step(1'b0, 3'd0, 1'b0, 8'd0);
    check_out("f6_idle", 1'b0, 1'b0, EMP, EMP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
